// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI Mode 0 responder.
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int         SYNC_STAGES    = 2;
  localparam logic [7:0] DUMMY_BYTE_DEF = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for one asynchronous SPI input, with a per-instance reset value.
module sync_2ff
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {SYNC_STAGES{RST_VAL}};
    else        sr <= {sr[SYNC_STAGES-2:0], d};
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 responder: oversamples SCK/CS_N/MOSI in the clk domain, receives bytes
// on a valid pulse and transmits bytes from a one-deep valid/ready holding register.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic [7:0] DUMMY_BYTE = DUMMY_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       cs_active,
  output logic       frame_done,
  output logic       tx_underrun
);

  logic sck_s, cs_s, mosi_s;
  logic sck_d, cs_d;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(spi_clk),  .q(sck_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

  // Edge-detect stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_d <= 1'b0;
      cs_d  <= 1'b1;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  logic cs_fall, cs_rise, sck_rise, sck_fall;

  assign cs_fall  =  cs_d & ~cs_s;
  assign cs_rise  = ~cs_d &  cs_s;
  assign sck_rise = ~cs_s &  sck_s & ~sck_d;
  assign sck_fall = ~cs_s & ~sck_s &  sck_d;

  state_t     state;
  logic [2:0] bit_cnt;
  logic       reload;
  logic       hold_full;
  logic [7:0] hold_data;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;

  logic       load;
  logic       capture;
  logic [7:0] next_byte;
  logic       take_hold;
  logic       underrun;

  assign load     = ((state == IDLE) && cs_fall) ||
                    ((state == ACTIVE) && sck_fall && reload);
  assign tx_ready = ~hold_full;
  // A byte offered while a load is taking place bypasses the holding register.
  assign capture  = tx_valid && !hold_full && !load;

  always_comb begin
    next_byte = DUMMY_BYTE;
    take_hold = 1'b0;
    underrun  = 1'b0;
    if (hold_full) begin
      next_byte = hold_data;
      take_hold = 1'b1;
    end else if (tx_valid) begin
      next_byte = tx_data;
    end else begin
      underrun  = 1'b1;
    end
  end

  // Control and output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      reload      <= 1'b0;
      hold_full   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      cs_active   <= 1'b0;
      frame_done  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      tx_underrun <= load && underrun;

      if (load && take_hold) hold_full <= 1'b0;
      else if (capture)      hold_full <= 1'b1;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            bit_cnt     <= 3'd0;
            reload      <= 1'b0;
            spi_miso    <= next_byte[7];
            spi_miso_oe <= 1'b1;
            cs_active   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            reload      <= 1'b0;
            spi_miso_oe <= 1'b0;
            cs_active   <= 1'b0;
            frame_done  <= 1'b1;
          end else begin
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {rx_sr[6:0], mosi_s};
                rx_valid <= 1'b1;
                reload   <= 1'b1;
              end
            end
            if (sck_fall) begin
              reload   <= 1'b0;
              spi_miso <= reload ? next_byte[7] : tx_sr[6];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift-register datapath, no reset: every byte is loaded before it is used
  always_ff @(posedge clk) begin
    if (capture) hold_data <= tx_data;

    if (load)                                tx_sr <= next_byte;
    else if ((state == ACTIVE) && sck_fall)  tx_sr <= {tx_sr[6:0], 1'b0};

    if ((state == ACTIVE) && sck_rise)       rx_sr <= {rx_sr[6:0], mosi_s};
  end

endmodule
